pcre_chain_engine: RTL

PCRE_CHAIN_ENGINE -- requirements
Module: pcre_chain_engine

---
 rtl/pcre_chain_engine.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pcre_chain_engine.sv
// Linear regex state chain: one state per pattern element, with optional star (zero-or-more) states.
// Each byte's char-class hits come from the shared decoder; match is sticky per frame with the first-match offset.
module pcre_chain_engine #(
    parameter int NUM_CLASSES = 40,
    parameter int MAX_STATES  = 32,
    parameter int CNT_W       = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            sod,
    input  logic                            eod,
    input  logic [NUM_CLASSES-1:0]          class_vec,
    input  logic                            cfg_we,
    input  logic [$clog2(MAX_STATES)-1:0]   cfg_addr,
    input  logic [$clog2(NUM_CLASSES)-1:0]  cfg_class,
    input  logic                            cfg_star,
    input  logic [$clog2(MAX_STATES):0]     cfg_len,
    input  logic                            cfg_anchor,
    output logic                            match,
    output logic [CNT_W-1:0]                match_offset,
    output logic                            done,
    output logic                            busy,
    output logic                            cfg_err
);

    localparam int AW = $clog2(MAX_STATES);
    localparam int CW = $clog2(NUM_CLASSES);
    localparam int LW = AW + 1;

    logic [CW-1:0]         cls_q [MAX_STATES];
    logic [CW-1:0]         cls_d [MAX_STATES];
    logic [MAX_STATES-1:0] star_q, star_d;
    logic [LW-1:0]         len_q, len_d;
    logic                  anchor_q, anchor_d;

    logic [MAX_STATES-1:0] s_q, s_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  match_q, match_d;
    logic [CNT_W-1:0]      off_q, off_d;
    logic                  first_q, first_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cfg_err_q, cfg_err_d;

    logic [LW-1:0]         len_eff;
    logic                  first;
    logic [MAX_STATES-1:0] s_base, s_calc;
    logic [MAX_STATES:0]   f, fn;
    logic                  hit;
    logic                  acc;
    logic [CNT_W-1:0]      cnt_base;

    // Feed chain f uses the pre-update states; acceptance chain fn uses the freshly computed
    // states so a trailing star run accepts in the same cycle as the byte that reaches it.
    always_comb begin
        len_eff = (len_q > LW'(MAX_STATES)) ? LW'(MAX_STATES) : len_q;
        first   = sod | first_q;
        s_base  = sod ? '0 : s_q;
        f       = '0;
        fn      = '0;
        s_calc  = '0;
        hit     = 1'b0;
        f[0]    = ~anchor_q | first;
        fn[0]   = ~anchor_q;
        for (int unsigned i = 0; i < MAX_STATES; i++) begin
            hit = 1'b0;
            for (int unsigned j = 0; j < NUM_CLASSES; j++) begin
                if (cls_q[i] == CW'(j)) hit = class_vec[j];
            end
            f[i+1]    = s_base[i] | (star_q[i] & f[i]);
            s_calc[i] = (LW'(i) < len_eff) & hit & (f[i] | (star_q[i] & s_base[i]));
            fn[i+1]   = s_calc[i] | (star_q[i] & fn[i]);
        end
        acc = (len_eff != '0) & fn[len_eff];
    end

    always_comb begin
        s_d       = s_q;
        cnt_d     = cnt_q;
        match_d   = match_q;
        off_d     = off_q;
        first_d   = first_q;
        busy_d    = busy_q;
        done_d    = en & eod;
        cfg_err_d = cfg_we & busy_q;
        cnt_base  = sod ? '0 : cnt_q;

        if (sod) begin
            s_d     = '0;
            cnt_d   = '0;
            match_d = 1'b0;
            off_d   = '0;
            first_d = 1'b1;
            busy_d  = 1'b1;
        end
        if (en) begin
            s_d     = s_calc;
            cnt_d   = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
            first_d = 1'b0;
            if (acc && !match_d) begin
                match_d = 1'b1;
                off_d   = cnt_d;
            end
            if (eod) busy_d = 1'b0;
        end
    end

    always_comb begin
        cls_d    = cls_q;
        star_d   = star_q;
        len_d    = len_q;
        anchor_d = anchor_q;
        if (cfg_we && !busy_q) begin
            if (int'(cfg_addr) < MAX_STATES) begin
                cls_d[cfg_addr]  = cfg_class;
                star_d[cfg_addr] = cfg_star;
            end
            len_d    = cfg_len;
            anchor_d = cfg_anchor;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MAX_STATES; i++) cls_q[i] <= '0;
            star_q    <= '0;
            len_q     <= '0;
            anchor_q  <= 1'b0;
            s_q       <= '0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
            off_q     <= '0;
            first_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < MAX_STATES; i++) cls_q[i] <= cls_d[i];
            star_q    <= star_d;
            len_q     <= len_d;
            anchor_q  <= anchor_d;
            s_q       <= s_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            off_q     <= off_d;
            first_q   <= first_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign match        = match_q;
    assign match_offset = off_q;
    assign done         = done_q;
    assign busy         = busy_q;
    assign cfg_err      = cfg_err_q;

endmodule
